// File: rtl/xorshift_lanes_pkg.sv
// Shared constants, lane state type and seed helper for the xorshift lane array.
package xorshift_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned WARM_CNT_W = 8;

  localparam logic [WORD_W-1:0] SEED_X      = 32'd123456789;
  localparam logic [WORD_W-1:0] SEED_Y      = 32'd362436069;
  localparam logic [WORD_W-1:0] SEED_Z      = 32'd521288629;
  localparam logic [WORD_W-1:0] SEED_W      = 32'd88675123;
  localparam logic [WORD_W-1:0] LANE_SPREAD = 32'h9E3779B9;

  // x in the top word, w in the bottom word
  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] z;
    logic [WORD_W-1:0] w;
  } lane_state_t;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fsm_state_e;

  // Default seed of a lane: legacy seed XOR lane*spread (mod 2^32)
  function automatic lane_state_t default_seed(input int unsigned lane);
    logic [WORD_W-1:0] k;
    lane_state_t s;
    k   = WORD_W'(lane) * LANE_SPREAD;
    s.x = SEED_X ^ k;
    s.y = SEED_Y ^ k;
    s.z = SEED_Z ^ k;
    s.w = SEED_W ^ k;
    return s;
  endfunction

endpackage

// File: rtl/xorshift_lanes_if.sv
// Control, seed load and output stream of the xorshift lane array.
interface xorshift_lanes_if
  import xorshift_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4
) ();
  logic                        en;
  logic                        restart;
  logic                        seed_we;
  logic [LANE_IDX_W-1:0]       seed_lane;
  lane_state_t                 seed_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W*NUM_LANES-1:0] out_data;
  logic [WORD_W-1:0]           gen_count;

  modport master (
    output en, restart, seed_we, seed_lane, seed_data, out_ready,
    input  out_valid, out_data, gen_count
  );

  modport slave (
    input  en, restart, seed_we, seed_lane, seed_data, out_ready,
    output out_valid, out_data, gen_count
  );
endinterface

// File: rtl/xorshift_lanes_lane.sv
// One xorshift128 generator: state registers, step, seed load and zero-seed guard.
module xorshift_lane
  import xorshift_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_default,
  input  logic              load_seed,
  input  lane_state_t       seed_data,
  input  logic              step,
  output logic [WORD_W-1:0] w
);

  localparam lane_state_t DFLT = default_seed(LANE);

  lane_state_t st;

  function automatic lane_state_t xs_step(input lane_state_t s);
    logic [WORD_W-1:0] t;
    lane_state_t n;
    t   = s.x ^ (s.x << 11);
    n.x = s.y;
    n.y = s.z;
    n.z = s.w;
    n.w = (s.w ^ (s.w >> 19)) ^ (t ^ (t >> 8));
    return n;
  endfunction

  // State update: default reload > seed load (zero state replaced) > step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= DFLT;
    end else if (load_default) begin
      st <= DFLT;
    end else if (load_seed) begin
      st <= (seed_data == '0) ? DFLT : seed_data;
    end else if (step) begin
      st <= xs_step(st);
    end
  end

  assign w = st.w;

endmodule

// File: rtl/xorshift_lanes.sv
// Array of xorshift128 lanes with warm-up FSM, valid/ready output and transfer counter.
module xorshift_lanes
  import xorshift_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned WARMUP    = 16
) (
  input logic             clk,
  input logic             rst_n,
  xorshift_lanes_if.slave bus
);

  localparam logic [WARM_CNT_W-1:0] WARM_INIT = WARM_CNT_W'(WARMUP);
  localparam fsm_state_e            INIT_ST   = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  fsm_state_e                  state;
  logic [WARM_CNT_W-1:0]       warm_cnt;
  logic [WORD_W-1:0]           gen_cnt_q;
  logic                        seed_hit;
  logic                        step_c;
  logic [WORD_W-1:0]           lane_w [NUM_LANES];
  logic [WORD_W*NUM_LANES-1:0] data_c;

  assign seed_hit = bus.seed_we && (WORD_W'(bus.seed_lane) < NUM_LANES);

  // Lane step: warm-up steps continue across a seed load, fires never coincide with a reload
  always_comb begin
    step_c = 1'b0;
    if (!bus.restart) begin
      if (seed_hit) begin
        step_c = bus.en && (state == ST_WARMUP);
      end else if (bus.en) begin
        step_c = (state == ST_WARMUP) || bus.out_ready;
      end
    end
  end

  // FSM, warm-up counter and transfer counter; en low freezes all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_ST;
      warm_cnt  <= WARM_INIT;
      gen_cnt_q <= '0;
    end else if (bus.restart) begin
      state     <= INIT_ST;
      warm_cnt  <= WARM_INIT;
      gen_cnt_q <= '0;
    end else if (seed_hit) begin
      state    <= INIT_ST;
      warm_cnt <= WARM_INIT;
    end else if (bus.en) begin
      if (state == ST_WARMUP) begin
        warm_cnt <= warm_cnt - WARM_CNT_W'(1);
        if (warm_cnt <= WARM_CNT_W'(1)) begin
          state <= ST_RUN;
        end
      end else if (bus.out_ready) begin
        gen_cnt_q <= gen_cnt_q + WORD_W'(1);
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    xorshift_lane #(
      .LANE(l)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_default (bus.restart),
      .load_seed    (seed_hit && (bus.seed_lane == LANE_IDX_W'(l))),
      .seed_data    (bus.seed_data),
      .step         (step_c),
      .w            (lane_w[l])
    );
  end

  // Pack lane w registers, lane L in word L
  always_comb begin
    data_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      data_c[WORD_W*i +: WORD_W] = lane_w[i];
    end
  end

  assign bus.out_data  = data_c;
  assign bus.out_valid = (state == ST_RUN) && bus.en;
  assign bus.gen_count = gen_cnt_q;

endmodule

// File: tb/tb_xorshift_lanes.sv
// Bench for xorshift_lanes: reference model with per-cycle compare plus directed checks.
module tb_xorshift_lanes;
  import xorshift_pkg::*;

  localparam int unsigned NL   = 4;
  localparam int unsigned WARM = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  xorshift_lanes_if #(.NUM_LANES(NL)) bus  ();
  xorshift_lanes_if #(.NUM_LANES(NL)) bus0 ();

  xorshift_lanes #(.NUM_LANES(NL), .WARMUP(WARM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  xorshift_lanes #(.NUM_LANES(NL), .WARMUP(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // ---------------- reference model ----------------
  logic [127:0] ms [NL];
  logic [31:0]  m_gen;
  int           m_warm;
  bit           m_run;
  logic [31:0]  seq [0:40];

  function automatic logic [127:0] dflt(input int l);
    logic [31:0] k;
    k = 32'(l) * 32'h9E3779B9;
    return {32'd123456789 ^ k, 32'd362436069 ^ k, 32'd521288629 ^ k, 32'd88675123 ^ k};
  endfunction

  function automatic logic [127:0] xs_next(input logic [127:0] s);
    logic [31:0] x, y, z, w, t, nw;
    {x, y, z, w} = s;
    t  = x ^ (x << 11);
    nw = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {y, z, w, nw};
  endfunction

  function automatic logic [31:0] wof(input logic [127:0] s);
    return s[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_out(input int l);
    logic [127:0] d;
    d = 128'(bus.out_data);
    return d[32*l +: 32];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) ms[l] = dflt(l);
      m_gen  = 0;
      m_warm = WARM;
      m_run  = (WARM == 0);
    end else if (bus.restart) begin
      for (int l = 0; l < NL; l++) ms[l] = dflt(l);
      m_gen  = 0;
      m_warm = WARM;
      m_run  = (WARM == 0);
    end else if (bus.seed_we && (bus.seed_lane < 3'd4)) begin
      for (int l = 0; l < NL; l++) begin
        if (l == int'(bus.seed_lane))
          ms[l] = (bus.seed_data == '0) ? dflt(l) : 128'(bus.seed_data);
        else if (bus.en && !m_run)
          ms[l] = xs_next(ms[l]);
      end
      m_warm = WARM;
      m_run  = (WARM == 0);
    end else if (bus.en) begin
      if (!m_run) begin
        for (int l = 0; l < NL; l++) ms[l] = xs_next(ms[l]);
        m_warm--;
        if (m_warm == 0) m_run = 1'b1;
      end else if (bus.out_ready) begin
        for (int l = 0; l < NL; l++) ms[l] = xs_next(ms[l]);
        m_gen++;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_run && bus.en));
    chk("cyc_gen_count", bus.gen_count, m_gen);
    for (int l = 0; l < NL; l++) chk($sformatf("cyc_lane%0d_w", l), lane_out(l), wof(ms[l]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [127:0] d0;
    seq[0] = 32'd88675123;
    d0 = dflt(0);
    for (int i = 1; i <= 40; i++) begin
      d0 = xs_next(d0);
      seq[i] = d0[31:0];
    end

    bus.en = 1'b0; bus.restart = 1'b0; bus.seed_we = 1'b0; bus.seed_lane = '0;
    bus.seed_data = '0; bus.out_ready = 1'b0;
    bus0.en = 1'b1; bus0.restart = 1'b0; bus0.seed_we = 1'b0; bus0.seed_lane = '0;
    bus0.seed_data = '0; bus0.out_ready = 1'b1;

    // model pins: legacy sequence
    chk("model_seq1", seq[1], 32'd3701687786);
    chk("model_seq2", seq[2], 32'd458299110);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;

    // reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_gen_count", bus.gen_count, 32'd0);
    chk("rst_lane0_w", lane_out(0), 32'd88675123);
    chk("rst_lane1_w", lane_out(1), 32'd88675123 ^ 32'h9E3779B9);
    chk("w0_first_word", bus0.out_data[31:0], 32'd88675123);
    chk("w0_valid", 32'(bus0.out_valid), 32'd1);

    // warm-up, first half (WARMUP=0 instance fires meanwhile)
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("warm_a_out_valid", 32'(bus.out_valid), 32'd0);
      if (i == 0) chk("w0_second_word", bus0.out_data[31:0], 32'd3701687786);
      if (i == 1) chk("w0_third_word", bus0.out_data[31:0], 32'd458299110);
      if (i == 2) chk("w0_gen_count", bus0.gen_count, 32'd3);
    end
    // pause warm-up
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("warm_b_out_valid", 32'(bus.out_valid), 32'd0);
    end
    cyc();
    chk("run_entry_valid", 32'(bus.out_valid), 32'd1);
    chk("run_entry_word", lane_out(0), seq[16]);
    chk("run_entry_gen", bus.gen_count, 32'd0);

    // three fires
    for (int i = 0; i < 3; i++) cyc();
    chk("fire3_gen", bus.gen_count, 32'd3);
    chk("fire3_word", lane_out(0), seq[19]);

    // backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_word", lane_out(0), seq[19]);
      chk("stall_gen", bus.gen_count, 32'd3);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end

    // en low in RUN
    bus.en = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("en_low_valid", 32'(bus.out_valid), 32'd0);
    chk("en_low_gen", bus.gen_count, 32'd3);
    bus.en = 1'b1;
    bus.out_ready = 1'b0;

    // zero seed into lane 2
    bus.seed_we = 1'b1; bus.seed_lane = 3'd2; bus.seed_data = '0;
    cyc();
    bus.seed_we = 1'b0;
    chk("seed0_valid", 32'(bus.out_valid), 32'd0);
    chk("seed0_gen", bus.gen_count, 32'd3);
    chk("seed0_lane2", lane_out(2), 32'd88675123 ^ (32'd2 * 32'h9E3779B9));
    chk("seed0_lane0_hold", lane_out(0), seq[19]);

    // nonzero seed into lane 1 during warm-up
    for (int i = 0; i < 4; i++) cyc();
    bus.seed_we = 1'b1; bus.seed_lane = 3'd1;
    bus.seed_data = 128'h00000001_00000002_00000003_00000004;
    cyc();
    bus.seed_we = 1'b0;
    chk("seed1_lane1_w", lane_out(1), 32'd4);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("reseed_warm_valid", 32'(bus.out_valid), 32'd0);
    end
    cyc();
    chk("reseed_run_valid", 32'(bus.out_valid), 32'd1);

    // out-of-range seed lane is ignored
    bus.seed_we = 1'b1; bus.seed_lane = 3'd7;
    bus.seed_data = 128'h12345678_9abcdef0_0fedcba9_87654321;
    cyc();
    bus.seed_we = 1'b0;
    chk("bad_lane_valid", 32'(bus.out_valid), 32'd1);
    chk("bad_lane_gen", bus.gen_count, 32'd3);

    // restart coincident with a fire
    bus.out_ready = 1'b1;
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    chk("restart_gen", bus.gen_count, 32'd0);
    chk("restart_valid", 32'(bus.out_valid), 32'd0);
    chk("restart_lane0", lane_out(0), 32'd88675123);
    chk("restart_lane3", lane_out(3), 32'd88675123 ^ (32'd3 * 32'h9E3779B9));

    // back to RUN and fire twice
    for (int i = 0; i < 18; i++) cyc();
    chk("rerun_gen", bus.gen_count, 32'd2);
    chk("rerun_word", lane_out(0), seq[18]);

    // asynchronous reset mid-RUN
    @(posedge clk);
    #3;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_gen", bus.gen_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("post_rst_gen", bus.gen_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xorshift_lanes.md
XORSHIFT_LANES -- requirements
Module: xorshift_lanes

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of independent 32-bit xorshift128 generators (legal 1..8).
REQ-002 SHALL have parameter WARMUP, default 16, number of discarded steps after reset, restart or seed load (legal 0..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  global enable; low freezes all state and forces out_valid low.
REQ-006 SHALL have port restart  input  1  synchronous reload of all lanes with their default seeds.
REQ-007 SHALL have port seed_we  input  1  single-cycle strobe that loads seed_data into lane seed_lane.
REQ-008 SHALL have port seed_lane  input  3  target lane index for seed_we.
REQ-009 SHALL have port seed_data  input  128  new state {x,y,z,w}, with x in bits [127:96] and w in bits [31:0].
REQ-010 SHALL have port out_valid  output  1  out_data holds a fresh, unconsumed word set.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-012 SHALL have port out_data  output  32*NUM_LANES  w register of each lane; lane L in bits [32L+31:32L].
REQ-013 SHALL have port gen_count  output  32  number of accepted transfers, wrapping modulo 2^32.

Function
REQ-014 Each lane SHALL hold x,y,z,w; one step = x<=y, y<=z, z<=w, w<=(w^(w>>19))^(t^(t>>8)) with t=x^(x<<11), all arithmetic 32-bit unsigned, shifted-out bits discarded.
REQ-015 Default seed of lane L SHALL be x=123456789, y=362436069, z=521288629, w=88675123, each XORed with (L*32'h9E3779B9) mod 2^32; lane 0 therefore reproduces the legacy single-lane sequence.
REQ-016 The FSM SHALL have two states: WARMUP and RUN.
REQ-017 In WARMUP with en=1, all lanes SHALL step every cycle and a warm-up counter SHALL decrement; on the step that brings the counter to 0 the FSM SHALL enter RUN.
REQ-018 Entry into WARMUP with WARMUP=0 SHALL go directly to RUN with no discarded steps.
REQ-019 out_valid SHALL be 1 exactly when state=RUN and en=1; out_data SHALL be the registered w values (zero combinational latency from state).
REQ-020 In RUN, all lanes SHALL step together on the cycle where out_valid&out_ready=1 (fire) and SHALL hold otherwise; gen_count SHALL increment on each fire.
REQ-021 en=0 SHALL freeze lane state, the FSM, the warm-up counter and gen_count; it SHALL NOT reset anything.
REQ-022 restart=1 SHALL load default seeds into all lanes, clear gen_count, reload the warm-up counter with WARMUP and enter WARMUP, regardless of en.
REQ-023 seed_we=1 with seed_lane<NUM_LANES SHALL load seed_data into that lane, reload the warm-up counter and enter WARMUP; other lanes step this cycle only if they would have stepped anyway; gen_count is kept.
REQ-024 An all-zero seed_data SHALL be replaced by that lane's default seed (a zero state is a fixed point).
REQ-025 seed_we with seed_lane>=NUM_LANES SHALL be ignored completely.
REQ-026 Priority SHALL be rst_n > restart > seed_we > step; a fire coincident with restart or a seed load SHALL be neither counted nor stepped.
REQ-027 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously load default seeds, clear gen_count to 0, load the warm-up counter with WARMUP and set the FSM to WARMUP (RUN if WARMUP=0); out_valid SHALL therefore be 0 during reset.
REQ-029 Reset deassertion SHALL be synchronised by the surrounding system; the block SHALL take no action on the first edge other than normal operation.

Structure
REQ-030 A shared package xorshift_pkg SHALL hold the four default seed constants, the lane-spread constant 32'h9E3779B9 and the 128-bit lane state typedef.
REQ-031 The per-lane state registers, step function, seed load and zero-seed guard SHALL be implemented in sub-module xorshift_lane, instantiated NUM_LANES times; the FSM, warm-up counter and gen_count SHALL live in the top module.

Verification
REQ-032 WARMUP=0 with out_ready=1 after reset: lane 0 out_data = 88675123, 3701687786, 458299110 on three consecutive cycles; gen_count = 3 after those three fires.
REQ-033 WARMUP=16: out_valid stays 0 for 16 enabled cycles after reset, and the first lane 0 word equals the 17th word of the REQ-032 sequence.
REQ-034 Hold out_ready=0 for 5 cycles in RUN: out_data and gen_count remain unchanged; with en toggled low mid-warm-up, the warm-up pauses and resumes without skipping steps.
REQ-035 seed_we to lane 2 with seed_data=0: lane 2 restarts from its default seed; seed_lane=7 with NUM_LANES=4: no state change.
REQ-036 restart and fire in the same cycle: gen_count is cleared to 0 (not 1), all lanes hold their defaults, and the FSM enters WARMUP; rst_n pulsed mid-RUN: out_valid drops immediately (asynchronously).
